// File: rtl/fc_flatten_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_flatten_loader                                                          |
// | Streams Conv2 feature-map planes from Global SRAM into the FC buffer.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fc_flatten_loader #(
  parameter int SRAM_ADDR_W = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 16,
  parameter int FMAP_H      = 5,
  parameter int FMAP_W      = 5,
  parameter int ROW_STRIDE  = 8,
  parameter int CH_STRIDE   = 64,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_async_i,
  input  logic                   start_i,
  input  logic [SRAM_ADDR_W-1:0] sram_base_i,
  input  logic [9:0]             buf_base_i,
  output logic                   sram_rd_req_o,
  output logic [SRAM_ADDR_W-1:0] sram_rd_addr_o,
  input  logic                   sram_rd_gnt_i,
  input  logic [DATA_W-1:0]      sram_rd_data_i,
  output logic                   buf_wr_en_o,
  output logic [9:0]             buf_wr_addr_o,
  output logic [DATA_W-1:0]      buf_wr_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int C_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int C_ROW_W = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
  localparam int C_COL_W = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [SRAM_ADDR_W-1:0] r_sram_base;
  logic [9:0]             r_buf_base;
  logic [C_CH_W-1:0]      r_ch;
  logic [C_ROW_W-1:0]     r_row;
  logic [C_COL_W-1:0]     r_col;
  logic [RD_LAT-1:0]      r_vld_pipe;
  logic [9:0]             r_wr_cnt;
  logic                   r_wr_en;
  logic [9:0]             r_wr_addr;
  logic [DATA_W-1:0]      r_wr_data;

  logic                   w_fire;
  logic                   w_last_col;
  logic                   w_last_row;
  logic                   w_last_ch;
  logic                   w_last_elem;
  logic                   w_pipe_empty;
  logic [SRAM_ADDR_W-1:0] w_ch_off;
  logic [SRAM_ADDR_W-1:0] w_row_off;

  // Address arithmetic is done at SRAM width so it wraps naturally.
  assign w_ch_off       = SRAM_ADDR_W'(r_ch) * SRAM_ADDR_W'(CH_STRIDE);
  assign w_row_off      = SRAM_ADDR_W'(r_row) * SRAM_ADDR_W'(ROW_STRIDE);
  assign sram_rd_addr_o = r_sram_base + w_ch_off + w_row_off + SRAM_ADDR_W'(r_col);

  assign w_last_col   = (r_col == C_COL_W'(FMAP_W - 1));
  assign w_last_row   = (r_row == C_ROW_W'(FMAP_H - 1));
  assign w_last_ch    = (r_ch == C_CH_W'(NUM_CH - 1));
  assign w_last_elem  = w_last_col && w_last_row && w_last_ch;
  assign w_fire       = (r_state == S_ISSUE) && sram_rd_gnt_i;
  assign w_pipe_empty = ~|r_vld_pipe;

  assign sram_rd_req_o = (r_state == S_ISSUE);
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign buf_wr_en_o   = r_wr_en;
  assign buf_wr_addr_o = r_wr_addr;
  assign buf_wr_data_o = r_wr_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_fire && w_last_elem) w_state_nxt = S_DRAIN;
      // An empty pipe means the final write is already on the output register.
      S_DRAIN: if (w_pipe_empty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      r_sram_base <= '0;
      r_buf_base  <= '0;
      r_ch        <= '0;
      r_row       <= '0;
      r_col       <= '0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_sram_base <= sram_base_i;
      r_buf_base  <= buf_base_i;
      r_ch        <= '0;
      r_row       <= '0;
      r_col       <= '0;
    end else if (w_fire) begin
      if (w_last_col) begin
        r_col <= '0;
        if (w_last_row) begin
          r_row <= '0;
          r_ch  <= w_last_ch ? '0 : r_ch + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Return path: the tail of the valid pipe marks the cycle read data is valid.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      r_vld_pipe <= '0;
      r_wr_cnt   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_vld_pipe[0] <= w_fire;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
      r_wr_en <= r_vld_pipe[RD_LAT-1];
      if ((r_state == S_IDLE) && start_i) begin
        r_wr_cnt <= '0;
      end else if (r_vld_pipe[RD_LAT-1]) begin
        r_wr_data <= sram_rd_data_i;
        r_wr_addr <= r_buf_base + r_wr_cnt;
        r_wr_cnt  <= r_wr_cnt + 10'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_flatten_loader.sv
`default_nettype none
// Bench for fc_flatten_loader: SRAM model with random contents and a flatten-order
// reference model; instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
module tb_fc_flatten_loader;

  localparam int N = 400;

  typedef struct packed {
    int dev;
    int cyc;
    int a;
    int v;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic [15:0] sbase [2];
  logic [9:0]  bbase [2];
  logic        gnt   [2];
  logic [7:0]  rdata [2];
  logic        req   [2];
  logic [15:0] raddr [2];
  logic        wen   [2];
  logic [9:0]  waddr [2];
  logic [7:0]  wdata [2];
  logic        busy  [2];
  logic        done  [2];

  logic [7:0]  mem [0:65535];
  int          lat [2] = '{1, 3};
  int          gmode [2];
  bit          pv [2][5];
  logic [15:0] pa [2][5];
  bit          stall_prev [2];
  logic [15:0] addr_prev [2];
  int          stall_err;
  int          cyc = 0;
  ev_t         wq[$];
  ev_t         gq[$];
  ev_t         dq[$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_flatten_loader #(.RD_LAT(1)) u_dut (
    .clk_i(clk), .rst_async_i(rst), .start_i(start[0]),
    .sram_base_i(sbase[0]), .buf_base_i(bbase[0]),
    .sram_rd_req_o(req[0]), .sram_rd_addr_o(raddr[0]),
    .sram_rd_gnt_i(gnt[0]), .sram_rd_data_i(rdata[0]),
    .buf_wr_en_o(wen[0]), .buf_wr_addr_o(waddr[0]), .buf_wr_data_o(wdata[0]),
    .busy_o(busy[0]), .done_o(done[0])
  );

  fc_flatten_loader #(.RD_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_async_i(rst), .start_i(start[1]),
    .sram_base_i(sbase[1]), .buf_base_i(bbase[1]),
    .sram_rd_req_o(req[1]), .sram_rd_addr_o(raddr[1]),
    .sram_rd_gnt_i(gnt[1]), .sram_rd_data_i(rdata[1]),
    .buf_wr_en_o(wen[1]), .buf_wr_addr_o(waddr[1]), .buf_wr_data_o(wdata[1]),
    .busy_o(busy[1]), .done_o(done[1])
  );

  // SRAM arbiter/memory model and event recorder, evaluated mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      gnt[d] = (gmode[d] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (stall_prev[d] && req[d] && (raddr[d] !== addr_prev[d])) stall_err++;
      stall_prev[d] = req[d] && !gnt[d];
      addr_prev[d]  = raddr[d];
      for (int k = 4; k > 0; k--) begin
        pv[d][k] = pv[d][k-1];
        pa[d][k] = pa[d][k-1];
      end
      pv[d][0] = req[d] && gnt[d];
      pa[d][0] = raddr[d];
      if (req[d] && gnt[d]) gq.push_back('{d, cyc, int'(raddr[d]), 0});
      rdata[d] = pv[d][lat[d]] ? mem[pa[d][lat[d]]] : 8'($urandom);
      if (wen[d]) wq.push_back('{d, cyc, int'(waddr[d]), int'(wdata[d])});
      if (done[d]) dq.push_back('{d, cyc, 0, 0});
    end
  end

  function automatic int exp_sram(input int sb, input int k);
    int ch, r, c;
    ch = k / 25;
    r  = (k / 5) % 5;
    c  = k % 5;
    return (sb + ch * 64 + r * 8 + c) & 16'hFFFF;
  endfunction

  function automatic int exp_buf(input int bb, input int k);
    return (bb + k) % 1024;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs;
    wq.delete();
    gq.delete();
    dq.delete();
    stall_err = 0;
  endtask

  task automatic do_start(input int d, input int sb, input int bb, output int t0);
    tick;
    start[d] = 1'b1;
    sbase[d] = 16'(sb);
    bbase[d] = 10'(bb);
    t0 = cyc;
    tick;
    start[d] = 1'b0;
    sbase[d] = 16'($urandom);
    bbase[d] = 10'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({req[d], raddr[d], wen[d], waddr[d], wdata[d], busy[d], done[d]} !== '0)
        $display("FAIL reset_outputs dev%0d: got %h expected 0", d,
                 {req[d], raddr[d], wen[d], waddr[d], wdata[d], busy[d], done[d]});
      else n_pass++;
    end
    rst = 1'b0;
    repeat (3) tick;
    n_chk++;
    if (busy[0] !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", busy[0]);
    else n_pass++;
  endtask

  task automatic test_linear;
    int t0, k, errs, busy_errs;
    clear_logs();
    gmode[0] = 0;
    do_start(0, 16'h0800, 0, t0);
    busy_errs = 0;
    for (int i = 0; i < 410; i++) begin
      if (busy[0] !== ((cyc - t0) >= 1 && (cyc - t0) <= 403)) busy_errs++;
      tick;
    end
    k = 0; errs = 0;
    foreach (wq[i]) begin
      if (wq[i].a != k || wq[i].v != (k & 255)) errs++;
      k++;
    end
    n_chk++;
    if (k !== N) $display("FAIL lin_count: writes=%0d expected=%0d", k, N); else n_pass++;
    n_chk++;
    if (errs !== 0) $display("FAIL lin_data: bad pairs=%0d expected 0", errs); else n_pass++;
    n_chk++;
    if (wq.size() == 0 || wq[wq.size()-1].cyc - t0 !== 402)
      $display("FAIL lin_last_write: cycle=%0d expected 402",
               (wq.size() == 0) ? -1 : wq[wq.size()-1].cyc - t0);
    else n_pass++;
    n_chk++;
    if (dq.size() !== 1 || dq[0].cyc - t0 !== 403)
      $display("FAIL lin_done: pulses=%0d first=%0d expected 1 at 403", dq.size(),
               (dq.size() == 0) ? -1 : dq[0].cyc - t0);
    else n_pass++;
    n_chk++;
    if (busy_errs !== 0) $display("FAIL lin_busy: bad cycles=%0d expected 0", busy_errs);
    else n_pass++;
  endtask

  task automatic test_random_gnt;
    int t0, k, errs, aerrs, lerrs, sb, bb, budget;
    clear_logs();
    gmode[0] = 1;
    sb = int'($urandom_range(0, 65535));
    bb = int'($urandom_range(0, 1023));
    do_start(0, sb, bb, t0);
    budget = 3000;
    while (dq.size() == 0 && budget > 0) begin
      tick;
      budget--;
    end
    repeat (5) tick;
    gmode[0] = 0;
    n_chk++;
    if (budget == 0) $display("FAIL rnd_timeout: no done within 3000 cycles"); else n_pass++;
    k = 0; errs = 0; aerrs = 0; lerrs = 0;
    foreach (wq[i]) begin
      if (wq[i].a != exp_buf(bb, k) || wq[i].v != int'(mem[exp_sram(sb, k)])) errs++;
      if (k < gq.size() && wq[i].cyc - gq[k].cyc != 2) lerrs++;
      k++;
    end
    foreach (gq[i]) if (gq[i].a != exp_sram(sb, i)) aerrs++;
    n_chk++;
    if (k !== N) $display("FAIL rnd_count: writes=%0d expected=%0d", k, N); else n_pass++;
    n_chk++;
    if (errs !== 0) $display("FAIL rnd_data: bad pairs=%0d expected 0", errs); else n_pass++;
    n_chk++;
    if (aerrs !== 0 || gq.size() !== N)
      $display("FAIL rnd_rd_addr: bad=%0d grants=%0d expected 0/%0d", aerrs, gq.size(), N);
    else n_pass++;
    n_chk++;
    if (lerrs !== 0) $display("FAIL rnd_latency: bad=%0d expected 0", lerrs); else n_pass++;
    n_chk++;
    if (stall_err !== 0) $display("FAIL rnd_stall_addr: changes=%0d expected 0", stall_err);
    else n_pass++;
    n_chk++;
    if (dq.size() !== 1 || wq.size() == 0 || dq[0].cyc - wq[wq.size()-1].cyc !== 1)
      $display("FAIL rnd_done: pulses=%0d gap=%0d expected 1/1", dq.size(),
               (dq.size() == 0 || wq.size() == 0) ? -1 : dq[0].cyc - wq[wq.size()-1].cyc);
    else n_pass++;
  endtask

  task automatic test_lat3;
    int t0, k, errs, lerrs, sb, bb;
    clear_logs();
    gmode[1] = 0;
    sb = int'($urandom_range(0, 65535));
    bb = int'($urandom_range(0, 1023));
    do_start(1, sb, bb, t0);
    repeat (412) tick;
    k = 0; errs = 0; lerrs = 0;
    foreach (wq[i]) begin
      if (wq[i].a != exp_buf(bb, k) || wq[i].v != int'(mem[exp_sram(sb, k)])) errs++;
      if (k >= gq.size() || wq[i].cyc - gq[k].cyc != 4) lerrs++;
      k++;
    end
    n_chk++;
    if (k !== N) $display("FAIL lat3_count: writes=%0d expected=%0d", k, N); else n_pass++;
    n_chk++;
    if (errs !== 0) $display("FAIL lat3_data: bad pairs=%0d expected 0", errs); else n_pass++;
    n_chk++;
    if (lerrs !== 0) $display("FAIL lat3_latency: bad=%0d expected 0", lerrs); else n_pass++;
    n_chk++;
    if (dq.size() !== 1 || dq[0].cyc - t0 !== 405)
      $display("FAIL lat3_done: pulses=%0d first=%0d expected 1 at 405", dq.size(),
               (dq.size() == 0) ? -1 : dq[0].cyc - t0);
    else n_pass++;
  endtask

  task automatic test_buf_wrap;
    int t0, k, errs, sb;
    clear_logs();
    gmode[0] = 0;
    sb = int'($urandom_range(0, 65535));
    do_start(0, sb, 1000, t0);
    repeat (410) tick;
    k = 0; errs = 0;
    foreach (wq[i]) begin
      if (wq[i].a != exp_buf(1000, k) || wq[i].v != int'(mem[exp_sram(sb, k)])) errs++;
      k++;
    end
    n_chk++;
    if (k !== N || errs !== 0) $display("FAIL wrap_data: writes=%0d bad=%0d expected %0d/0", k, errs, N);
    else n_pass++;
    n_chk++;
    if (wq.size() < 25 || wq[23].a !== 1023 || wq[24].a !== 0)
      $display("FAIL wrap_addr: elem23=%0d elem24=%0d expected 1023/0",
               (wq.size() < 25) ? -1 : wq[23].a, (wq.size() < 25) ? -1 : wq[24].a);
    else n_pass++;
  endtask

  task automatic test_start_ignore;
    int t0, k1, k2, e1, e2, sb1, sb3, bb1, bb3;
    clear_logs();
    gmode[0] = 0;
    sb1 = int'($urandom_range(0, 65535)); bb1 = int'($urandom_range(0, 1023));
    sb3 = int'($urandom_range(0, 65535)); bb3 = int'($urandom_range(0, 1023));
    do_start(0, sb1, bb1, t0);
    repeat (98) tick;
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    while (cyc < t0 + 403) tick;
    n_chk++;
    if (done[0] !== 1'b1) $display("FAIL ign_done_cycle: done=%b expected 1", done[0]); else n_pass++;
    start[0] = 1'b1;
    sbase[0] = 16'($urandom);
    tick;
    sbase[0] = 16'(sb3);
    bbase[0] = 10'(bb3);
    tick;
    start[0] = 1'b0;
    while (cyc < t0 + 812) tick;
    k1 = 0; k2 = 0; e1 = 0; e2 = 0;
    foreach (wq[i]) begin
      if (wq[i].cyc <= t0 + 403) begin
        if (wq[i].a != exp_buf(bb1, k1) || wq[i].v != int'(mem[exp_sram(sb1, k1)])) e1++;
        k1++;
      end else begin
        if (wq[i].a != exp_buf(bb3, k2) || wq[i].v != int'(mem[exp_sram(sb3, k2)])) e2++;
        k2++;
      end
    end
    n_chk++;
    if (k1 !== N || e1 !== 0) $display("FAIL ign_first_load: writes=%0d bad=%0d expected %0d/0", k1, e1, N);
    else n_pass++;
    n_chk++;
    if (k2 !== N || e2 !== 0) $display("FAIL ign_second_load: writes=%0d bad=%0d expected %0d/0", k2, e2, N);
    else n_pass++;
    n_chk++;
    if (dq.size() !== 2 || dq[0].cyc - t0 !== 403 || dq[1].cyc - t0 !== 807)
      $display("FAIL ign_done_pulses: count=%0d expected 2 at 403/807", dq.size());
    else n_pass++;
  endtask

  task automatic test_reset_midload;
    int t0, k, errs, sb, bb, budget;
    clear_logs();
    gmode[0] = 0;
    do_start(0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 1023)), t0);
    budget = 1000;
    while (wq.size() < 200 && budget > 0) begin
      tick;
      budget--;
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({req[0], raddr[0], wen[0], waddr[0], wdata[0], busy[0], done[0]} !== '0)
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {req[0], raddr[0], wen[0], waddr[0], wdata[0], busy[0], done[0]});
    else n_pass++;
    repeat (4) tick;
    rst = 1'b0;
    repeat (10) tick;
    n_chk++;
    if (wq.size() !== 200 || dq.size() !== 0)
      $display("FAIL rst_mid_abort: writes=%0d dones=%0d expected 200/0", wq.size(), dq.size());
    else n_pass++;
    clear_logs();
    sb = int'($urandom_range(0, 65535));
    bb = int'($urandom_range(0, 1023));
    do_start(0, sb, bb, t0);
    budget = 600;
    while (dq.size() == 0 && budget > 0) begin
      tick;
      budget--;
    end
    k = 0; errs = 0;
    foreach (wq[i]) begin
      if (wq[i].a != exp_buf(bb, k) || wq[i].v != int'(mem[exp_sram(sb, k)])) errs++;
      k++;
    end
    n_chk++;
    if (budget == 0 || k !== N || errs !== 0)
      $display("FAIL rst_reload: writes=%0d bad=%0d budget=%0d expected %0d/0/>0", k, errs, budget, N);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    stall_err = 0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      sbase[d] = '0;
      bbase[d] = '0;
      gnt[d]   = 1'b0;
      rdata[d] = '0;
      gmode[d] = 0;
    end
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < N; k++) mem[exp_sram(16'h0800, k)] = 8'(k);
    test_reset();
    test_linear();
    test_random_gnt();
    test_lat3();
    test_buf_wrap();
    test_start_ignore();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
